// File: rtl/hopfield_seq_network.sv
// hopfield_seq_network
// Time-multiplexed binary Hopfield network with on-chip Hebbian learning.
// A single accumulator walks the weight matrix one entry per cycle. Learning
// touches one (i,j) pair per cycle. Recall updates neurons one at a time in
// index order, so each update is seen by the neurons that follow it.
// Optional feature macro: HOPFIELD_WEIGHT_READ_EN adds a combinational
// weight read port (rd_row, rd_col, rd_data).
// Handshake: start is taken only in IDLE (busy=0), together with mode and
// pattern_in. busy stays high until the done pulse, and busy drops in the cycle
// after done. A start seen while busy, or in the done cycle, is dropped.
module hopfield_seq_network #(
    parameter int N          = 7,
    parameter int WEIGHT_W   = 8,
    parameter int MAX_SWEEPS = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [N-1:0]                      pattern_in,
    output logic                              busy,
    output logic                              done,
    output logic [N-1:0]                      state_out,
    output logic                              converged,
    output logic [$clog2(MAX_SWEEPS+1)-1:0]   sweep_count
`ifdef HOPFIELD_WEIGHT_READ_EN
    ,
    input  logic [$clog2(N)-1:0]              rd_row,
    input  logic [$clog2(N)-1:0]              rd_col,
    output logic signed [WEIGHT_W-1:0]        rd_data
`endif
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(MAX_SWEEPS + 1);
    localparam int AW = WEIGHT_W + $clog2(N) + 1;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [SW-1:0] SWEEP_LAST = SW'(MAX_SWEEPS - 1);
    localparam logic signed [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] WMIN = -WMAX;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEARN  = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [N-1:0]               pat_q, pat_d;
    logic [IW-1:0]              i_q, i_d;
    logic [IW-1:0]              j_q, j_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic                       changed_q, changed_d;
    logic                       conv_q, conv_d;
    logic [SW-1:0]              sweep_q, sweep_d;
    logic [N-1:0]               so_q, so_d;
    logic signed [WEIGHT_W-1:0] w_q [N][N];
    logic signed [WEIGHT_W-1:0] w_d [N][N];

    logic signed [WEIGHT_W-1:0] wij;
    logic signed [AW-1:0]       w_ext;
    logic signed [AW-1:0]       term;
    logic                       acc_neg;
    logic                       acc_pos;
    logic                       new_bit;
    logic                       same;

    // Next-state logic: FSM, counters, accumulator, neuron states and weights
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        changed_d = changed_q;
        conv_d    = conv_q;
        sweep_d   = sweep_q;
        so_d      = so_q;
        w_d       = w_q;

        wij   = w_q[i_q][j_q];
        w_ext = AW'(wij);
        term  = so_q[j_q] ? w_ext : -w_ext;
        if (i_q == j_q) begin
            term = '0;
        end
        acc_neg = acc_q[AW-1];
        acc_pos = !acc_neg && (acc_q != '0);
        new_bit = acc_pos ? 1'b1 : (acc_neg ? 1'b0 : so_q[i_q]);
        same    = (pat_q[i_q] == pat_q[j_q]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d = pattern_in;
                    i_d   = '0;
                    j_d   = '0;
                    if (mode) begin
                        so_d      = pattern_in;
                        acc_d     = '0;
                        sweep_d   = '0;
                        changed_d = 1'b0;
                        conv_d    = 1'b0;
                        state_d   = S_ACCUM;
                    end else begin
                        state_d = S_LEARN;
                    end
                end
            end
            S_LEARN: begin
                // Hebbian step with saturation; the diagonal stays at zero
                if (i_q != j_q) begin
                    if (same) begin
                        if (wij != WMAX) begin
                            w_d[i_q][j_q] = wij + WEIGHT_W'(1);
                        end
                    end else begin
                        if (wij != WMIN) begin
                            w_d[i_q][j_q] = wij - WEIGHT_W'(1);
                        end
                    end
                end
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + term;
                if (j_q == LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_UPDATE: begin
                // A zero sum keeps the neuron's current value
                so_d[i_q] = new_bit;
                if (new_bit != so_q[i_q]) begin
                    changed_d = 1'b1;
                end
                acc_d = '0;
                j_d   = '0;
                if (i_q == LAST) begin
                    state_d = S_CHECK;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_ACCUM;
                end
            end
            S_CHECK: begin
                sweep_d = sweep_q + SW'(1);
                if (!changed_q) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (sweep_q == SWEEP_LAST) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    changed_d = 1'b0;
                    i_d       = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including the weight matrix
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            changed_q <= 1'b0;
            conv_q    <= 1'b0;
            sweep_q   <= '0;
            so_q      <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            changed_q <= changed_d;
            conv_q    <= conv_d;
            sweep_q   <= sweep_d;
            so_q      <= so_d;
            w_q       <= w_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign state_out   = so_q;
    assign converged   = conv_q;
    assign sweep_count = sweep_q;

`ifdef HOPFIELD_WEIGHT_READ_EN
    // Combinational weight read; indices outside the matrix return zero
    always_comb begin
        rd_data = '0;
        if ((int'(rd_row) < N) && (int'(rd_col) < N)) begin
            rd_data = w_q[rd_row][rd_col];
        end
    end
`endif

endmodule

// File: tb/tb_hopfield_seq_network.sv
// Testbench for hopfield_seq_network (N=7, WEIGHT_W=8, MAX_SWEEPS=15).
// Drivers issue learn/recall operations and push the expected completion
// record; a monitor pops a record on every done pulse and compares it.
// Weight read-port checks exist only when HOPFIELD_WEIGHT_READ_EN is defined.
module tb_hopfield_seq_network;

    localparam int N  = 7;
    localparam int WW = 8;
    localparam int MS = 15;
    localparam int SW = $clog2(MS + 1);
    localparam int IW = $clog2(N);
    localparam int EW = 1 + N + 1 + SW + 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [N-1:0]  pattern_in;
    logic          busy;
    logic          done;
    logic [N-1:0]  state_out;
    logic          converged;
    logic [SW-1:0] sweep_count;
`ifdef HOPFIELD_WEIGHT_READ_EN
    logic [IW-1:0]        rd_row;
    logic [IW-1:0]        rd_col;
    logic signed [WW-1:0] rd_data;
`endif

    hopfield_seq_network #(
        .N(N),
        .WEIGHT_W(WW),
        .MAX_SWEEPS(MS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .pattern_in(pattern_in),
        .busy(busy),
        .done(done),
        .state_out(state_out),
        .converged(converged),
        .sweep_count(sweep_count)
`ifdef HOPFIELD_WEIGHT_READ_EN
        ,
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_data(rd_data)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int acc_cyc   = 0;
    int done_seen = 0;

    localparam int LAT_LEARN  = N * N + 1;           // 50
    localparam int LAT_SWEEP1 = N * (N + 1) + 2;     // 58
    localparam int LAT_SWEEP2 = 2 * N * (N + 1) + 3; // 115

    function automatic logic [EW-1:0] mk_exp(input logic is_rec, input logic [N-1:0] st,
                                             input logic conv, input logic [SW-1:0] sw,
                                             input int lat);
        return {is_rec, st, conv, sw, 16'(lat)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires one expected record.
    // Latency is the count of rising edges from the accept edge to the first
    // edge at which done is sampled high.
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done with empty queue, required none");
            end else begin
                mon_e = exp_q.pop_front();
                check("latency", cyc - acc_cyc + 1, int'(mon_e[15:0]));
                if (mon_e[EW-1]) begin
                    check("state_out", int'(state_out), int'(mon_e[EW-2 -: N]));
                    check("converged", int'(converged), int'(mon_e[SW+16]));
                    check("sweep_count", int'(sweep_count), int'(mon_e[SW+15:16]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic m, input logic [N-1:0] p, input logic [EW-1:0] e);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            total_cnt++;
            $display("FAIL idle_wait: busy=%0d, required 0", busy);
        end
        start      = 1'b1;
        mode       = m;
        pattern_in = p;
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        int guard;
        int seen0;
        guard = 0;
        seen0 = done_seen;
        while (done_seen == seen0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (done_seen == seen0) begin
            total_cnt++;
            $display("FAIL done_timeout: no done after %0d cycles", guard);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_state_out"}, int'(state_out), 0);
        check({tag, "_converged"}, int'(converged), 0);
        check({tag, "_sweep_count"}, int'(sweep_count), 0);
    endtask

`ifdef HOPFIELD_WEIGHT_READ_EN
    task automatic rd_check(input int r, input int c, input int exp);
        rd_row = IW'(r);
        rd_col = IW'(c);
        #1;
        check($sformatf("w[%0d][%0d]", r, c), int'(rd_data), exp);
    endtask

    task automatic rd_all_zero(input int lim);
        for (int r = 0; r < lim; r++) begin
            for (int c = 0; c < lim; c++) begin
                rd_check(r, c, 0);
            end
        end
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        pattern_in = '0;
`ifdef HOPFIELD_WEIGHT_READ_EN
        rd_row = '0;
        rd_col = '0;
`endif
        // reset asserted mid-cycle takes effect immediately
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("reset");
`ifdef HOPFIELD_WEIGHT_READ_EN
        rd_all_zero(8);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single learn of 1010101
        run_op(1'b0, 7'b1010101, mk_exp(1'b0, '0, 1'b0, '0, LAT_LEARN));
        wait_done();
`ifdef HOPFIELD_WEIGHT_READ_EN
        rd_check(0, 2, 1);
        rd_check(0, 1, -1);
        rd_check(3, 3, 0);
        rd_check(1, 0, -1);
`endif

        // recall of the stored pattern: stable after one sweep
        run_op(1'b1, 7'b1010101, mk_exp(1'b1, 7'b1010101, 1'b1, SW'(1), LAT_SWEEP1));
        wait_done();

        // recall with bit0 flipped: restored in first sweep, confirmed in second
        run_op(1'b1, 7'b1010100, mk_exp(1'b1, 7'b1010101, 1'b1, SW'(2), LAT_SWEEP2));
        wait_done();
        repeat (3) @(negedge clk);
        check("state_hold", int'(state_out), int'(7'b1010101));

        // 130 more learns drive weights into saturation
        for (int k = 0; k < 130; k++) begin
            run_op(1'b0, 7'b1010101, mk_exp(1'b0, '0, 1'b0, '0, LAT_LEARN));
            wait_done();
        end
`ifdef HOPFIELD_WEIGHT_READ_EN
        rd_check(0, 2, 127);
        rd_check(0, 1, -127);
        rd_check(6, 5, -127);
        rd_check(4, 4, 0);
        rd_check(7, 0, 0);
        rd_check(2, 7, 0);
`endif

        // two bits flipped (0 and 6): both restored, second sweep confirms
        run_op(1'b1, 7'b0010100, mk_exp(1'b1, 7'b1010101, 1'b1, SW'(2), LAT_SWEEP2));
        wait_done();

        // a learn request while recalling is ignored
        run_op(1'b1, 7'b1010100, mk_exp(1'b1, 7'b1010101, 1'b1, SW'(2), LAT_SWEEP2));
        repeat (10) @(negedge clk);
        start      = 1'b1;
        mode       = 1'b0;
        pattern_in = 7'b0000000;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_recall", int'(busy), 1);
        wait_done();

        // reset while in ACCUM aborts and clears weights
        run_op(1'b1, 7'b1010101, mk_exp(1'b1, 7'b1010101, 1'b1, SW'(1), LAT_SWEEP1));
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        check_reset_outputs("abort");
`ifdef HOPFIELD_WEIGHT_READ_EN
        rd_all_zero(N);
`endif
        @(negedge clk);
        reset = 1'b0;

        // with zero weights every sum ties, so the initial state is kept
        run_op(1'b1, 7'b0110011, mk_exp(1'b1, 7'b0110011, 1'b1, SW'(1), LAT_SWEEP1));
        wait_done();

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
